mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DEPTH, default 4, meaning per-operand FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cfg_valid  input  1  configuration request.
REQ-005 cfg_ready  output  1  high only in IDLE; a configuration is accepted when cfg_valid && cfg_ready.
REQ-006 cfg_float  input  1  data type: 1 = fp16, 0 = int8.
REQ-007 cfg_len  input  8  pair count; 0 encodes 256.
REQ-008 a_valid / a_ready / a_data  input / output / input  1/1/16  operand-A stream.
REQ-009 b_valid / b_ready / b_data  input / output / input  1/1/16  operand-B stream.
REQ-010 config_en  output  1  MAC configuration strobe.
REQ-011 float_int  output  1  registered data type to the MAC.
REQ-012 data_num  output  8  registered cfg_len to the MAC.
REQ-013 in_a / in_b  output  16  paired operands.
REQ-014 in_valid_a / in_valid_b  output  1  operand valids; always equal to each other.
REQ-015 done  output  1  one-cycle pulse after the last pair is issued.

Function
REQ-016 States: IDLE, CONF, STREAM, DONE; no other state is reachable.
REQ-017 IDLE -> CONF when a configuration is accepted; cfg_float and cfg_len are latched on that edge.
REQ-018 CONF lasts exactly 2 cycles with config_en=1; in_valid_* stay 0; it then moves to STREAM.
REQ-019 float_int and data_num change only on configuration acceptance and are otherwise held.
REQ-020 A pair issues in STREAM on each cycle where both FIFOs are non-empty: in_valid_a=in_valid_b=1 for that cycle, in_a/in_b are the FIFO heads, and both FIFOs pop on that edge.
REQ-021 No partial issue: if either FIFO is empty, in_valid_* = 0 and neither FIFO pops.
REQ-022 in_a/in_b/in_valid_* are registered outputs, with one-cycle latency from pop decision to the output.
REQ-023 An 8-bit pair counter clears on acceptance and increments per issued pair; after pair N (N = cfg_len, or 256 if 0), the FSM moves STREAM -> DONE.
REQ-024 DONE lasts 1 cycle with done=1, then IDLE; surplus FIFO contents are retained for the next job.
REQ-025 a_ready = !fullA and b_ready = !fullB in every state, so pre-filling during IDLE/CONF is allowed.
REQ-026 Push and pop in the same cycle leave the occupancy unchanged; pushes are ignored when full (ready low); pops never occur when empty.
REQ-027 FIFO pointers wrap modulo DEPTH; occupancy ranges over 0..DEPTH.
REQ-028 cfg_valid outside IDLE is ignored (cfg_ready=0).

Reset
REQ-029 On rst: state=IDLE, FIFOs empty, pair counter=0, float_int=0, data_num=0, config_en=0, in_valid_*=0, in_a=in_b=0, done=0, cfg_ready=1, a_ready=b_ready=1.
REQ-030 Reset mid-STREAM aborts the job immediately, discards all buffered operands, and issues no done pulse.

Structure
REQ-031 Shared package mac_pkg holds the state enum, DEPTH default, and the 256 length constant.
REQ-032 One sub-module mac_fifo (16-bit, DEPTH entries, with full/empty flags), instantiated twice for A and B.

Verification
REQ-033 cfg_len=3, int, A and B pre-filled with 3 words each -> config_en high 2 cycles, then 3 consecutive pairs, then done pulse, then IDLE.
REQ-034 A arrives 2 cycles before B each pair -> valids rise only when B arrives; in_a/in_b always carry matched indices; no pair is split.
REQ-035 cfg_len=0, fp, continuous streams -> exactly 256 pairs, then done; data_num=0, float_int=1 throughout.
REQ-036 A pushed 5 times with DEPTH=4 and no pops -> a_ready=0 after 4 pushes, 5th word held by the source and accepted after the first pop.
REQ-037 rst asserted after pair 2 of 5 -> all outputs at reset values asynchronously; FIFOs empty; no done pulse.
REQ-038 cfg_valid pulsed during STREAM -> ignored; float_int/data_num unchanged; job completes normally.

Source files
------------

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC operand feeder: FSM state type, default
// per-operand FIFO depth, the length encoded by cfg_len == 0, and the length
// of the configuration phase.
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int unsigned DEPTH_DEF   = 4;    // per-operand FIFO entries
    localparam int unsigned LEN_256     = 256;  // pair count encoded by cfg_len == 0
    localparam int unsigned CONF_CYCLES = 2;    // config_en strobe length

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONF,
        ST_STREAM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_feeder_if.sv
// ---------------------------------------------------------------------------
// mac_feeder_if
// Bundles the configuration handshake, the two operand streams and the
// MAC-side outputs of mac_feeder.
//   slave  : the feeder (consumes cfg/a/b, produces ready + MAC signals)
//   master : the environment driving the feeder
// ---------------------------------------------------------------------------
interface mac_feeder_if;

    // configuration request
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_float;
    logic [7:0]  cfg_len;

    // operand streams
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_data;

    // MAC side
    logic        config_en;
    logic        float_int;
    logic [7:0]  data_num;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_valid_a;
    logic        in_valid_b;
    logic        done;

    modport slave (
        input  cfg_valid, cfg_float, cfg_len,
        input  a_valid, a_data, b_valid, b_data,
        output cfg_ready, a_ready, b_ready,
        output config_en, float_int, data_num,
        output in_a, in_b, in_valid_a, in_valid_b, done
    );

    modport master (
        output cfg_valid, cfg_float, cfg_len,
        output a_valid, a_data, b_valid, b_data,
        input  cfg_ready, a_ready, b_ready,
        input  config_en, float_int, data_num,
        input  in_a, in_b, in_valid_a, in_valid_b, done
    );

endinterface

// File: rtl/mac_fifo.sv
// ---------------------------------------------------------------------------
// mac_fifo
// Single-clock FIFO with first-word-fall-through head output.
//   i_clk, i_rst : clock, asynchronous active-high reset (empties the FIFO)
//   i_push       : write i_wdata (ignored while full)
//   i_pop        : drop the head entry (ignored while empty)
//   o_rdata      : current head entry
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module mac_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = mac_pkg::DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;   // 0..DEPTH, one bit wider than the pointers
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: emptiness is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/mac_feeder.sv
// ---------------------------------------------------------------------------
// mac_feeder
// Buffers two 16-bit operand streams and issues them to a MAC strictly in
// matched pairs, after a two-cycle configuration strobe.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset; aborts any job, empties FIFOs
//   bus  : mac_feeder_if.slave
//          cfg_valid/cfg_ready/cfg_float/cfg_len  job configuration
//          a_*/b_*                                operand streams
//          config_en/float_int/data_num           MAC configuration
//          in_a/in_b/in_valid_a/in_valid_b        registered operand pair
//          done                                   one-cycle end-of-job pulse
// ---------------------------------------------------------------------------
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mac_feeder_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic        r_conf_cnt;
    logic [7:0]  r_pair_cnt;
    logic        r_float;
    logic [7:0]  r_len;
    logic [15:0] r_in_a;
    logic [15:0] r_in_b;
    logic        r_in_valid;

    logic [15:0] w_a_head;
    logic [15:0] w_b_head;
    logic        w_a_full;
    logic        w_a_empty;
    logic        w_b_full;
    logic        w_b_empty;
    logic        w_accept;
    logic        w_issue;
    logic        w_last;
    logic [8:0]  w_target;
    logic        w_cfg_ready;
    logic        w_config_en;
    logic        w_done;

    mac_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (bus.a_valid),
        .i_pop   (w_issue),
        .i_wdata (bus.a_data),
        .o_rdata (w_a_head),
        .o_full  (w_a_full),
        .o_empty (w_a_empty)
    );

    mac_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (bus.b_valid),
        .i_pop   (w_issue),
        .i_wdata (bus.b_data),
        .o_rdata (w_b_head),
        .o_full  (w_b_full),
        .o_empty (w_b_empty)
    );

    assign w_accept = bus.cfg_valid && (r_state == ST_IDLE);
    // Both FIFOs must hold a word; a single pop signal keeps them in lockstep.
    assign w_issue  = (r_state == ST_STREAM) && !w_a_empty && !w_b_empty;
    // 9-bit compare so that cfg_len == 0 runs the full 256 pairs.
    assign w_target = (r_len == '0) ? 9'(LEN_256) : {1'b0, r_len};
    assign w_last   = w_issue && (({1'b0, r_pair_cnt} + 9'd1) == w_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cfg_ready = 1'b0;
        w_config_en = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                if (w_accept) w_next = ST_CONF;
            end
            ST_CONF: begin
                w_config_en = 1'b1;
                if (r_conf_cnt == 1'(CONF_CYCLES - 1)) w_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conf_cnt <= '0;
            r_pair_cnt <= '0;
            r_float    <= 1'b0;
            r_len      <= '0;
            r_in_a     <= '0;
            r_in_b     <= '0;
            r_in_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_float    <= bus.cfg_float;
                r_len      <= bus.cfg_len;
                r_pair_cnt <= '0;
                r_conf_cnt <= '0;
            end else if (w_issue) begin
                r_pair_cnt <= r_pair_cnt + 8'd1;
            end
            if (r_state == ST_CONF) r_conf_cnt <= r_conf_cnt + 1'b1;
            r_in_valid <= w_issue;
            if (w_issue) begin
                r_in_a <= w_a_head;
                r_in_b <= w_b_head;
            end
        end
    end

    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.config_en  = w_config_en;
    assign bus.done       = w_done;
    assign bus.a_ready    = !w_a_full;
    assign bus.b_ready    = !w_b_full;
    assign bus.float_int  = r_float;
    assign bus.data_num   = r_len;
    assign bus.in_a       = r_in_a;
    assign bus.in_b       = r_in_b;
    assign bus.in_valid_a = r_in_valid;
    assign bus.in_valid_b = r_in_valid;

endmodule

// File: tb/tb_mac_feeder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mac_feeder
// Directed sequence of jobs with random operand data. The reference model is
// a pair of queues of accepted words: every issued pair must be the oldest
// unmatched A word together with the oldest unmatched B word, a job must
// produce exactly N pairs followed by a done pulse, and configuration values
// must hold for the whole job.
// ---------------------------------------------------------------------------
module tb_mac_feeder;

    logic clk;
    logic rst;

    mac_feeder_if bus ();

    mac_feeder #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] srcA[$];
    logic [15:0] srcB[$];
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    int   mode = 0;     // 0 continuous, 1 A leads B, 2 random gaps
    int   tc = 0;
    int   a_sent = 0;
    int   b_sent = 0;
    int   a_last_t = 0;
    bit   in_job = 0;
    logic exp_float = 1'b0;
    logic [7:0] exp_len = 8'd0;
    int   pairs = 0;
    int   conf_cycles = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   done_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        case (mode)
            1: begin
                bus.a_valid = (srcA.size() > 0) && (a_sent == b_sent);
                bus.b_valid = (srcB.size() > 0) && (b_sent < a_sent) && ((tc - a_last_t) >= 1);
            end
            2: begin
                bus.a_valid = (srcA.size() > 0) && ($urandom_range(0, 1) == 1);
                bus.b_valid = (srcB.size() > 0) && ($urandom_range(0, 1) == 1);
            end
            default: begin
                bus.a_valid = (srcA.size() > 0);
                bus.b_valid = (srcB.size() > 0);
            end
        endcase
        bus.a_data = (srcA.size() > 0) ? srcA[0] : 16'h0;
        bus.b_data = (srcB.size() > 0) ? srcB[0] : 16'h0;
    endtask

    task automatic observe();
        cyc++;
        chk("valid_a_eq_b", bus.in_valid_a, bus.in_valid_b);
        chk("float_int", bus.float_int, exp_float);
        chk("data_num", bus.data_num, exp_len);
        chk("conf_no_valid", bus.config_en & bus.in_valid_a, 0);
        if (!in_job) chk("idle_no_valid", bus.in_valid_a, 0);
        if (bus.config_en === 1'b1) conf_cycles++;
        if (bus.in_valid_a === 1'b1) begin
            chk("pair_available", (qa.size() > 0) && (qb.size() > 0), 1);
            if ((qa.size() > 0) && (qb.size() > 0)) begin
                chk("in_a", bus.in_a, qa.pop_front());
                chk("in_b", bus.in_b, qb.pop_front());
            end
            pairs++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        bit acc_a;
        bit acc_b;
        drive_sources();
        acc_a = (bus.a_valid === 1'b1) && (bus.a_ready === 1'b1);
        acc_b = (bus.b_valid === 1'b1) && (bus.b_ready === 1'b1);
        @(posedge clk);
        tc++;
        if (acc_a) begin
            qa.push_back(srcA.pop_front());
            a_sent++;
            a_last_t = tc;
        end
        if (acc_b) begin
            qb.push_back(srcB.pop_front());
            b_sent++;
        end
        @(negedge clk);
        observe();
    endtask

    task automatic add_words(input int na, input int nb);
        for (int i = 0; i < na; i++) srcA.push_back(16'($urandom));
        for (int i = 0; i < nb; i++) srcB.push_back(16'($urandom));
    endtask

    task automatic run_job(input bit fl, input logic [7:0] len, input int stop_at, input bit poke);
        int n;
        bit poked;
        n = (len == 8'd0) ? 256 : int'(len);
        poked = 1'b0;
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_float = fl;
        bus.cfg_len   = len;
        exp_float = fl;
        exp_len   = len;
        pairs = 0; conf_cycles = 0; done_cnt = 0;
        cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        in_job = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 0; k < n * 4 + 64; k++) begin
            if (done_cnt != 0) break;
            if ((stop_at > 0) && (pairs >= stop_at)) return;
            chk("cfg_ready_busy", bus.cfg_ready, 0);
            if (poke && !poked && (pairs >= 1)) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_float = ~fl;
                bus.cfg_len   = len ^ 8'h5A;
                poked = 1'b1;
            end else begin
                bus.cfg_valid = 1'b0;
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("pair_count", pairs, n);
        chk("conf_cycles", conf_cycles, 2);
        chk("done_with_last_pair", done_cyc, last_cyc);
        tick();
        chk("done_one_cycle", bus.done, 0);
        chk("back_to_idle", bus.cfg_ready, 1);
        chk("no_valid_after", bus.in_valid_a, 0);
        chk("single_done", done_cnt, 1);
        in_job = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_float = 1'b0;
        bus.cfg_len   = 8'd0;
        bus.a_valid   = 1'b0;
        bus.a_data    = 16'h0;
        bus.b_valid   = 1'b0;
        bus.b_data    = 16'h0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_a_ready", bus.a_ready, 1);
        chk("rst_b_ready", bus.b_ready, 1);
        chk("rst_config_en", bus.config_en, 0);
        chk("rst_valid", bus.in_valid_a, 0);
        chk("rst_in_a", bus.in_a, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_data_num", bus.data_num, 0);
        rst = 1'b0;

        // prefilled int job of 3 pairs
        mode = 0;
        add_words(3, 3);
        repeat (4) tick();
        run_job(1'b0, 8'd3, 0, 1'b0);
        chk("first_pair_cycle", first_cyc, 3);
        chk("last_pair_cycle", last_cyc, 5);

        // A leads B by two cycles
        mode = 1;
        add_words(6, 6);
        run_job(1'b0, 8'd6, 0, 1'b0);

        // back-pressure on A with no pops
        mode = 0;
        add_words(5, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_ready_fill", bus.a_ready, qa.size() < 4);
        end
        chk("b_ready_idle", bus.b_ready, 1);
        chk("fifth_word_held", srcA.size(), 1);
        add_words(0, 1);
        run_job(1'b0, 8'd1, 0, 1'b0);
        tick();
        chk("fifth_word_taken", srcA.size(), 0);
        chk("a_ready_after_pop", bus.a_ready, 0);
        // leftover A words are consumed by the next job
        add_words(0, 4);
        run_job(1'b1, 8'd4, 0, 1'b0);
        chk("a_ready_drained", bus.a_ready, 1);

        // reset after pair 2 of 5
        mode = 0;
        add_words(5, 5);
        run_job(1'b1, 8'd5, 2, 1'b0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_valid_a", bus.in_valid_a, 0);
        chk("abort_valid_b", bus.in_valid_b, 0);
        chk("abort_in_a", bus.in_a, 0);
        chk("abort_in_b", bus.in_b, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_config_en", bus.config_en, 0);
        chk("abort_float_int", bus.float_int, 0);
        chk("abort_data_num", bus.data_num, 0);
        chk("abort_cfg_ready", bus.cfg_ready, 1);
        chk("abort_a_ready", bus.a_ready, 1);
        chk("abort_b_ready", bus.b_ready, 1);
        qa.delete(); qb.delete(); srcA.delete(); srcB.delete();
        a_sent = 0; b_sent = 0;
        exp_float = 1'b0; exp_len = 8'd0;
        in_job = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (5) tick();
        chk("no_done_after_abort", done_cnt, 0);

        // cfg_valid pulsed mid-stream is ignored
        mode = 2;
        add_words(4, 4);
        run_job(1'b0, 8'd4, 0, 1'b1);

        // length 0 means 256 pairs, fp16
        mode = 0;
        add_words(256, 256);
        run_job(1'b1, 8'd0, 0, 1'b0);

        // random jobs
        for (int j = 0; j < 3; j++) begin
            int len;
            len  = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            add_words(len, len);
            run_job(1'($urandom_range(0, 1)), 8'(len), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
